// File: rtl/fir_mac_filter.sv
// Direct-form FIR filter with a single time-shared multiply-accumulate unit and valid/ready streams.
// Build option: define FIR_SAT_EN to saturate out-of-range results; otherwise they wrap.
module fir_mac_filter #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 8,
    parameter int SHIFT  = 14,
    localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS),
    localparam int AW    = $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_ovf,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [COEF_W-1:0] C_UNITY = COEF_W'(1) << SHIFT;
    localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0]  R_MAX   = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  R_MIN   = -(ACC_W'(1) << (DATA_W - 1));
    localparam logic [AW-1:0]            K_LAST  = AW'(NTAPS - 1);
    localparam logic [AW:0]              NTAPS_A = (AW + 1)'(NTAPS);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state, state_nxt;
    logic signed [DATA_W-1:0]  x [NTAPS];
    logic signed [COEF_W-1:0]  c [NTAPS];
    logic signed [ACC_W-1:0]   acc, acc_sum, r;
    logic signed [PROD_W-1:0]  prod;
    logic signed [DATA_W-1:0]  res;
    logic [AW-1:0]             k;
    logic                      accept, last, ovf, coef_ok;

    // Handshake flags decode straight from the state register, so no input reaches an output.
    assign s_ready = (state == IDLE);
    assign m_valid = (state == OUT);
    assign accept  = s_valid && s_ready;
    assign last    = (k == K_LAST);
    assign coef_ok = (state == IDLE) && coef_we && ({1'b0, coef_addr} < NTAPS_A);

    assign prod    = x[k] * c[k];
    assign acc_sum = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign r       = (acc_sum + RND) >>> SHIFT;
    assign ovf     = (r > R_MAX) || (r < R_MIN);

    always_comb begin
        res = r[DATA_W-1:0];
`ifdef FIR_SAT_EN
        if (r > R_MAX) res = R_MAX[DATA_W-1:0];
        else if (r < R_MIN) res = R_MIN[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: next state defaults to the current one so no path leaves it unassigned and infers a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)  state_nxt = MAC;
            MAC:     if (last)    state_nxt = OUT;
            OUT:     if (m_ready) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: delay line and coefficient bank are reset here because reset must restore identity passthrough.
            for (int i = 0; i < NTAPS; i++) begin
                x[i] <= '0;
                c[i] <= (i == 0) ? C_UNITY : '0;
            end
            acc    <= '0;
            k      <= '0;
            m_data <= '0;
            m_ovf  <= 1'b0;
        end else begin
            // A write in the accepting cycle lands before the first MAC cycle reads the bank.
            if (coef_ok) c[coef_addr] <= coef_wdata;
            if (accept) begin
                for (int i = NTAPS - 1; i > 0; i--) x[i] <= x[i-1];
                x[0] <= s_data;
                acc  <= '0;
                k    <= '0;
            end else if (state == MAC) begin
                acc <= acc_sum;
                k   <= k + 1'b1;
                if (last) begin
                    m_data <= res;
                    m_ovf  <= ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Scoreboard bench for fir_mac_filter: directed vectors push expected outputs, a monitor pops and compares.
module tb_fir_mac_filter;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int NTAPS  = 8;
    localparam int SHIFT  = 14;
    localparam int AW     = $clog2(NTAPS);

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data = '0;
    logic                     m_valid;
    logic                     m_ready = 1'b1;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_ovf;
    logic                     coef_we = 1'b0;
    logic [AW-1:0]            coef_addr = '0;
    logic signed [COEF_W-1:0] coef_wdata = '0;

    fir_mac_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ovf(m_ovf),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit o;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_accept = 0;
    int   hs_cyc = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: latency on each rising m_valid, data/ovf on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && !prev_valid) begin
                if (lat_q.size() > 0) check("latency", cyc - lat_q.pop_front(), NTAPS);
                else check("unexpected_valid", 1, 0);
            end
            if (m_valid && m_ready) begin
                hs_cyc = cyc + 1;
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.d);
                    check("m_ovf", m_ovf, e.o);
                end else begin
                    check("unexpected_output", 1, 0);
                end
            end
        end
        prev_valid = m_valid;
    end

    task automatic send(input int d, input bit expect_out, input int e, input bit e_ovf);
        int n = 0;
        s_valid = 1'b1;
        s_data  = DATA_W'(d);
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("accept_timeout", s_ready, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_accept = cyc;
        if (expect_out) begin
            exp_q.push_back('{d: e, o: e_ovf});
            lat_q.push_back(cyc);
        end
        s_valid = 1'b0;
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = AW'(a);
        coef_wdata = COEF_W'(v);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_m_valid", m_valid, 0);
        check("reset_s_ready", s_ready, 1);
        check("reset_m_data", m_data, 0);
        check("reset_m_ovf", m_ovf, 0);

        // Identity passthrough from the reset coefficient bank.
        send(100, 1, 100, 0);
        send(-200, 1, -200, 0);
        send(32767, 1, 32767, 0);
        drain();

        // Four-tap moving average on an impulse.
        do_reset();
        for (int i = 0; i < 4; i++) write_coef(i, 4096);
        for (int i = 4; i < NTAPS; i++) write_coef(i, 0);
        send(16384, 1, 4096, 0);
        for (int i = 1; i < 8; i++) send(0, 1, (i < 4) ? 4096 : 0, 0);
        drain();

        // Overflow: 60000 does not fit in 16 bits.
        do_reset();
        write_coef(0, 16384);
        write_coef(1, 16384);
        send(30000, 1, 30000, 0);
`ifdef FIR_SAT_EN
        send(30000, 1, 32767, 1);
`else
        send(30000, 1, -5536, 1);
`endif
        drain();

        // Rounding at the half-LSB boundary with c0 = 1.
        do_reset();
        write_coef(0, 1);
        send(8192, 1, 1, 0);
        send(8191, 1, 0, 0);
        send(-8192, 1, 0, 0);
        send(-8193, 1, -1, 0);
        drain();

        // Backpressure with a pending input sample.
        do_reset();
        m_ready = 1'b0;
        send(1234, 1, 1234, 0);
        s_valid = 1'b1;
        s_data  = 16'sd555;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", m_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_m_data_hold", m_data, 1234);
            check("bp_s_ready_low", s_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(555, 1, 555, 0);
        check("bp_pending_accept_cycle", last_accept, hs_cyc + 1);
        drain();

        // Coefficient write during MAC is ignored.
        send(777, 1, 777, 0);
        write_coef(0, 0);
        drain();
        send(888, 1, 888, 0);
        drain();

        // Reset in MAC cycle 3 discards the partial result.
        send(999, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_m_valid", m_valid, 0);
        check("midreset_s_ready", s_ready, 1);
        send(500, 1, 500, 0);
        drain();
        repeat (12) @(posedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_mac_filter.md
# fir_mac_filter

Parametrised direct-form FIR filter built around a single time-shared multiply-accumulate unit. It takes signed samples through a valid/ready input stream and produces rounded output samples on a valid/ready output stream. Coefficients can be rewritten at run time. It is the next generation of the fixed 16-bit `filter` block in the 1D filter chain and sits between the sample source and the output logger/DAC path.

## Interface
- DATA_W, 16, signed sample width, input and output
- COEF_W, 16, signed coefficient width
- NTAPS, 8, number of taps (≥2)
- SHIFT, 14, output scaling right-shift (1 ≤ SHIFT < COEF_W−1)
- Derived: ACC_W = DATA_W+COEF_W+$clog2(NTAPS); AW = $clog2(NTAPS)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  DATA_W  signed input sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output
- m_data  out  DATA_W  signed filtered sample
- m_ovf  out  1  result exceeded DATA_W range; qualified by m_valid
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  tap index
- coef_wdata  in  COEF_W  signed coefficient

## Operation
- Storage:
  - Delay line x[0..NTAPS−1]; x[0] holds the newest sample.
  - Coefficient bank c[0..NTAPS−1].
- Reset state:
  - All x = 0.
  - c[0] = 2^SHIFT; all other c = 0. This gives identity passthrough.
  - State IDLE; s_ready=1, m_valid=0, m_data=0, m_ovf=0.
- States:
  - IDLE: s_ready=1. On s_valid&&s_ready: shift the delay line (x[k]←x[k−1], x[0]←s_data), clear acc, set k=0, go to MAC.
  - MAC: s_ready=0. Each cycle acc += x[k]*c[k] and k++. On the edge where k=NTAPS−1, the final sum is rounded and saturated, registered into m_data/m_ovf, m_valid is set, and the state goes to OUT.
  - OUT: m_valid=1. m_data and m_ovf are held stable. On m_ready, m_valid is cleared and the state goes to IDLE.
- Arithmetic:
  - Products are full precision (DATA_W+COEF_W bits). acc is ACC_W bits, so it never overflows.
  - r = (acc + 2^(SHIFT−1)) >>> SHIFT: round half up, arithmetic shift.
  - Out of range means r > 2^(DATA_W−1)−1 or r < −2^(DATA_W−1); m_ovf is set when that is the case.
- Coefficient writes:
  - Take effect at the clock edge only when the state is IDLE and coef_addr < NTAPS.
  - Ignored otherwise: in MAC or OUT, or when the address is out of range.
  - A write in the same IDLE cycle as an input acceptance is used by that sample's computation.
- Boundary conditions:
  - s_valid while s_ready=0: the sample is not consumed; the source must hold it.
  - m_ready while m_valid=0: ignored.
  - Reset asserted in any state, including mid-MAC: next edge gives the reset state, and the partial result is discarded.

## Timing
- Input accepted at edge E0 → m_valid high after edge E0+NTAPS.
- With m_ready held at 1: OUT lasts 1 cycle, s_ready is high after edge E0+NTAPS+1, and the next accept is at E0+NTAPS+2. Throughput is 1 sample per NTAPS+2 cycles.
- Backpressure stretches OUT indefinitely. s_ready stays 0 throughout.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- FIR_SAT_EN:
  - Defined: out-of-range r saturates to 2^(DATA_W−1)−1 or −2^(DATA_W−1).
  - Undefined: m_data = r[DATA_W−1:0], i.e. two's-complement wrap.
  - m_ovf is produced identically in both builds.

## Test plan
All scenarios use default parameters (NTAPS=8, SHIFT=14, DATA_W=16).
- Identity after reset: feed 100, −200, 32767 with m_ready=1 → outputs 100, −200, 32767, each with m_valid exactly 8 edges after acceptance and m_ovf=0.
- Moving average: write c0..c3=4096 and c4..c7=0, then feed 16384 followed by seven zeros → outputs 4096, 4096, 4096, 4096, 0, 0, 0, 0.
- Overflow: write c0=c1=16384 and feed 30000, 30000 → outputs 30000 then 32767 with m_ovf=1. Without FIR_SAT_EN the second output is −5536, still with m_ovf=1.
- Rounding: write c0=1 and feed 8192, 8191, −8192, −8193 → outputs 1, 0, 0, −1.
- Backpressure and hazards:
  - Hold m_ready=0 for 5 cycles after m_valid → m_data stable, s_ready=0, and a pending s_valid sample is not consumed until one cycle after the handshake.
  - A coef_we issued during MAC has no effect.
- Reset mid-operation: assert reset in MAC cycle 3 → after the next edge m_valid=0 and s_ready=1. A following input of 500 produces 500, confirming coefficients and delay line were restored.
